shade_decoder: RTL and testbench
================================

// Module: shade_decoder
// PURPOSE
//   Inverse of the row shader. Samples the per-slot row bit-planes the shader emits
//   over one PWM frame and recovers the DEPTH-bit intensity of every row.
//   Shader contract: row j is on in slot n iff value_j > n.
//   Sits on the LED row bus as a loop-back monitor/checker.
//   Also used by benches to check shader output against the programmed values.
// PARAMETERS
//   ROWS   32  number of rows (LED lines) on the bus
//   DEPTH  5   intensity width in bits; frame length SLOTS = 2**DEPTH-1 (31)
// PORTS
//   clk           in   1           system clock, all state on rising edge
//   rst           in   1           asynchronous, active-high reset
//   frame_start   in   1           qualified by rows_valid; marks the sample as slot 0
//   rows_valid    in   1           rows carries one slot sample this cycle
//   rows          in   ROWS        row bit-plane, bit j = row j on
//   values        out  ROWS*DEPTH  decoded levels, row j at values[DEPTH*j +: DEPTH]
//   values_valid  out  1           one-cycle pulse: values updated
//   mono_err      out  1           one-cycle pulse with values_valid: frame not monotonic
//   resync        out  1           one-cycle pulse: partial frame discarded
// BEHAVIOUR
//   Reset
//     - Async reset forces state IDLE and clears slot counter, per-row counters
//       and seen-off flags.
//     - Outputs reset to: values=0, values_valid=0, mono_err=0, resync=0.
//   Cycles without rows_valid
//     - Change no state.
//     - frame_start without rows_valid is ignored.
//   IDLE
//     - Samples are ignored until rows_valid & frame_start.
//     - On that sample go to RUN.
//     - That sample is slot 0: count[j] = rows[j]; off[j] = ~rows[j]; slot = 1.
//   RUN, sample with frame_start=0
//     - Update every row: count[j] += rows[j]; off[j] |= ~rows[j]; slot += 1.
//     - Set row err[j] if rows[j]=1 while off[j] is already set.
//       This is a 0->1 transition inside the frame (the shader output must be
//       thermometer code).
//   Frame completion (sample at slot = SLOTS-1)
//     - Completion uses the updated counts, including the current sample.
//     - Next cycle: values <= final counts; values_valid=1;
//       mono_err = |err including this sample.
//     - Same edge: clear counters, flags and slot; stay in RUN, expecting slot 0.
//   RUN, sample with frame_start=1
//     - frame_start has priority over completion, even at slot SLOTS-1.
//     - If slot != 0: the partial frame is discarded.
//       Pulse resync next cycle; no values_valid; values are held.
//     - In all cases the sample restarts the frame as slot 0, same as the IDLE entry.
//   Slot 0 reached without frame_start
//     - Accepted; frame_start is optional once locked.
//   Width and range
//     - Counts are DEPTH bits; the maximum count is SLOTS, so they cannot overflow.
//     - The slot counter wraps SLOTS-1 -> 0.
//   Hold behaviour
//     - values holds between frames.
//     - values_valid, mono_err and resync are single-cycle registered pulses.
//   Latency
//     - Output registers update 1 clk after the last slot sample.
//   Reset mid-frame
//     - The frame is lost with no pulse.
//     - Return to IDLE and wait for the next frame_start.
// TESTING
//   1 Ramp: shader rows for value_j=j (slot i: rows = ~0<<(i+1)), frame_start on slot 0
//     -> one values_valid pulse 1 clk after slot 30; values[5j+:5]=j; mono_err=0.
//   2 Extremes: all rows 0 for 31 slots, then all rows 1 for 31 slots
//     -> values all 0, then all 31 (0x1F); two valid pulses.
//   3 Ramp with random rows_valid gaps (1-3 idle cycles) -> identical result to test 1.
//   4 frame_start at slot 12 -> resync pulse, no values_valid, values unchanged;
//     following full frame decodes correctly.
//   5 Row 3 pattern 0,0,1,1,0... (3 ones) -> values[19:15]=3 with mono_err=1;
//     other rows correct.
//   6 rst asserted mid-frame (slot 7) -> all outputs 0 immediately;
//     valid samples without frame_start ignored; the next framed frame decodes correctly.

Source files
------------

// File: rtl/shade_decoder.sv
// -----------------------------------------------------------------------------
// shade_decoder
//   Loop-back monitor for the row shader. It samples the per-slot row
//   bit-planes over one PWM frame of SLOTS = 2**DEPTH-1 slots. From these
//   samples it recovers each row's DEPTH-bit intensity, which is the number of
//   slots in which that row was on. It also flags frames where a row turns
//   back on after being off, because the shader must emit thermometer code.
//
// Handshake: a sample is taken only on cycles with rows_valid=1. On those
//   cycles frame_start=1 marks the sample as slot 0. Cycles with rows_valid=0
//   change no state, and frame_start is ignored on them.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   frame_start   sample is slot 0 (qualified by rows_valid)
//   rows_valid    rows carries one slot sample this cycle
//   rows          row bit-plane, bit j = row j on
//   values        decoded levels, row j at values[DEPTH*j +: DEPTH]
//   values_valid  one-cycle pulse: values updated
//   mono_err      one-cycle pulse with values_valid: a row was not monotonic
//   resync        one-cycle pulse: partial frame discarded
// -----------------------------------------------------------------------------
module shade_decoder #(
  parameter int ROWS  = 32,
  parameter int DEPTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic                    rows_valid,
  input  logic [ROWS-1:0]         rows,
  output logic [ROWS*DEPTH-1:0]   values,
  output logic                    values_valid,
  output logic                    mono_err,
  output logic                    resync
);

  localparam int               SLOTS     = (1 << DEPTH) - 1;
  localparam logic [DEPTH-1:0] LAST_SLOT = DEPTH'(SLOTS - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [DEPTH-1:0]        slot_q, slot_d;
  logic [ROWS*DEPTH-1:0]   count_q, count_d;
  logic [ROWS-1:0]         off_q, off_d;
  logic [ROWS-1:0]         err_q, err_d;
  logic [ROWS*DEPTH-1:0]   values_q, values_d;
  logic                    values_valid_q, values_valid_d;
  logic                    mono_err_q, mono_err_d;
  logic                    resync_q, resync_d;

  // Per-row counts with the current sample added, and counts for a fresh slot 0.
  logic [ROWS*DEPTH-1:0]   count_upd;
  logic [ROWS*DEPTH-1:0]   count_first;
  // A row that is on after it was already seen off breaks thermometer order.
  logic [ROWS-1:0]         err_upd;

  always_comb begin
    count_upd   = '0;
    count_first = '0;
    for (int j = 0; j < ROWS; j++) begin
      count_upd[DEPTH*j +: DEPTH]   = count_q[DEPTH*j +: DEPTH] + {{(DEPTH-1){1'b0}}, rows[j]};
      count_first[DEPTH*j +: DEPTH] = {{(DEPTH-1){1'b0}}, rows[j]};
    end
    err_upd = err_q | (rows & off_q);

    state_d        = state_q;
    slot_d         = slot_q;
    count_d        = count_q;
    off_d          = off_q;
    err_d          = err_q;
    values_d       = values_q;
    values_valid_d = 1'b0;
    mono_err_d     = 1'b0;
    resync_d       = 1'b0;

    if (rows_valid) begin
      if (frame_start) begin
        // frame_start wins over completion; a mid-frame restart drops the partial frame.
        if (state_q == ST_RUN && slot_q != '0) begin
          resync_d = 1'b1;
        end
        state_d = ST_RUN;
        slot_d  = DEPTH'(1);
        count_d = count_first;
        off_d   = ~rows;
        err_d   = '0;
      end else if (state_q == ST_RUN) begin
        if (slot_q == LAST_SLOT) begin
          // Last slot: publish counts including this sample and expect slot 0 next.
          values_d       = count_upd;
          values_valid_d = 1'b1;
          mono_err_d     = |err_upd;
          slot_d         = '0;
          count_d        = '0;
          off_d          = '0;
          err_d          = '0;
        end else begin
          slot_d  = slot_q + DEPTH'(1);
          count_d = count_upd;
          off_d   = off_q | ~rows;
          err_d   = err_upd;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      slot_q         <= '0;
      count_q        <= '0;
      off_q          <= '0;
      err_q          <= '0;
      values_q       <= '0;
      values_valid_q <= 1'b0;
      mono_err_q     <= 1'b0;
      resync_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      count_q        <= count_d;
      off_q          <= off_d;
      err_q          <= err_d;
      values_q       <= values_d;
      values_valid_q <= values_valid_d;
      mono_err_q     <= mono_err_d;
      resync_q       <= resync_d;
    end
  end

  assign values       = values_q;
  assign values_valid = values_valid_q;
  assign mono_err     = mono_err_q;
  assign resync       = resync_q;

endmodule

// File: tb/tb_shade_decoder.sv
// -----------------------------------------------------------------------------
// tb_shade_decoder
//   Drives shader-style row bit-planes into shade_decoder. A frame-level
//   reference model predicts the outputs. It keeps the samples of the current
//   frame in a queue. When the frame is complete, it computes each row's level
//   as the number of slots that row was on. It flags the frame when a row is on
//   after an earlier off slot.
// -----------------------------------------------------------------------------
module tb_shade_decoder;

  localparam int ROWS  = 32;
  localparam int DEPTH = 5;
  localparam int SLOTS = 31;
  localparam int VW    = ROWS * DEPTH;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            frame_start;
  logic            rows_valid;
  logic [ROWS-1:0] rows;
  logic [VW-1:0]   values;
  logic            values_valid;
  logic            mono_err;
  logic            resync;

  always #5 clk = ~clk;

  shade_decoder #(.ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .rows_valid   (rows_valid),
    .rows         (rows),
    .values       (values),
    .values_valid (values_valid),
    .mono_err     (mono_err),
    .resync       (resync)
  );

  // ---------------- scoreboard / model state ----------------
  int              checks = 0;
  int              errors = 0;
  logic [VW-1:0]   exp_q[$];
  logic [ROWS-1:0] frame_q[$];
  bit              locked;
  logic [VW-1:0]   held_values;
  bit              exp_valid, exp_mono, exp_resync;
  logic [ROWS-1:0] slot_rows [SLOTS];

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one accepted or ignored sample.
  task automatic model_sample(input bit fs, input logic [ROWS-1:0] r);
    logic [VW-1:0] v;
    bit            m;
    exp_valid  = 1'b0;
    exp_resync = 1'b0;
    exp_mono   = 1'b0;
    if (!locked && !fs) return;
    if (fs) begin
      if (locked && frame_q.size() != 0) exp_resync = 1'b1;
      frame_q.delete();
      locked = 1'b1;
    end
    frame_q.push_back(r);
    if (frame_q.size() == SLOTS) begin
      v = '0;
      m = 1'b0;
      for (int j = 0; j < ROWS; j++) begin
        int cnt;
        bit seen_off;
        cnt = 0;
        seen_off = 1'b0;
        for (int n = 0; n < SLOTS; n++) begin
          if (frame_q[n][j]) begin
            cnt++;
            if (seen_off) m = 1'b1;
          end else begin
            seen_off = 1'b1;
          end
        end
        v[DEPTH*j +: DEPTH] = cnt[DEPTH-1:0];
      end
      held_values = v;
      exp_valid   = 1'b1;
      exp_mono    = m;
      exp_q.push_back(v);
      frame_q.delete();
    end
  endtask

  task automatic compare_outputs();
    check("values_valid", VW'(values_valid), VW'(exp_valid));
    check("mono_err", VW'(mono_err), VW'(exp_mono));
    check("resync", VW'(resync), VW'(exp_resync));
    check("values_hold", values, held_values);
    if (values_valid) begin
      if (exp_q.size() == 0) check("spurious_valid", VW'(1), VW'(0));
      else check("frame_values", values, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit fs, input bit rv, input logic [ROWS-1:0] r);
    @(negedge clk);
    frame_start = fs;
    rows_valid  = rv;
    rows        = r;
    @(posedge clk);
    if (rv) begin
      model_sample(fs, r);
    end else begin
      exp_valid  = 1'b0;
      exp_mono   = 1'b0;
      exp_resync = 1'b0;
    end
    #1;
    compare_outputs();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cycle(bit'($urandom_range(0, 1)), 1'b0, $urandom);
  endtask

  function automatic logic [ROWS-1:0] shade(input int vals[ROWS], input int n);
    logic [ROWS-1:0] r;
    for (int j = 0; j < ROWS; j++) r[j] = (vals[j] > n);
    return r;
  endfunction

  function automatic void fill(input int vals[ROWS]);
    for (int n = 0; n < SLOTS; n++) slot_rows[n] = shade(vals, n);
  endfunction

  // Send slot_rows[first..last]; gaps of min_gap..max_gap idle cycles after each sample.
  task automatic send_rows(input bit fs, input int first, input int last,
                           input int min_gap, input int max_gap);
    for (int n = first; n <= last; n++) begin
      cycle(fs && (n == 0), 1'b1, slot_rows[n]);
      if (max_gap > 0) gap($urandom_range(min_gap, max_gap));
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    locked      = 1'b0;
    frame_q.delete();
    held_values = '0;
    exp_valid   = 1'b0;
    exp_mono    = 1'b0;
    exp_resync  = 1'b0;
    check("rst_values", values, '0);
    check("rst_valid", VW'(values_valid), '0);
    check("rst_mono", VW'(mono_err), '0);
    check("rst_resync", VW'(resync), '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int ramp [ROWS];
  int vals [ROWS];

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    rows_valid  = 1'b0;
    rows        = '0;
    locked      = 1'b0;
    held_values = '0;
    for (int j = 0; j < ROWS; j++) ramp[j] = j;
    #1;
    check("por_values", values, '0);
    check("por_valid", VW'(values_valid), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Ramp, value_j = j.
    fill(ramp);
    send_rows(1'b1, 0, SLOTS - 1, 0, 0);
    check("ramp_row5", VW'(values[25 +: 5]), VW'(5));
    check("ramp_row31", VW'(values[155 +: 5]), VW'(31));

    // Extremes: all off, then all on (slot 0 of the second frame without frame_start).
    for (int j = 0; j < ROWS; j++) vals[j] = 0;
    fill(vals);
    send_rows(1'b1, 0, SLOTS - 1, 0, 0);
    check("all_zero", values, '0);
    for (int j = 0; j < ROWS; j++) vals[j] = 31;
    fill(vals);
    send_rows(1'b0, 0, SLOTS - 1, 0, 0);
    check("all_ones", values, {VW{1'b1}});

    // Ramp with 1-3 idle cycles between samples.
    fill(ramp);
    send_rows(1'b1, 0, SLOTS - 1, 1, 3);
    check("gap_ramp_row20", VW'(values[100 +: 5]), VW'(20));

    // frame_start at slot 12 discards the partial frame.
    send_rows(1'b1, 0, 11, 0, 0);
    cycle(1'b1, 1'b1, slot_rows[0]);
    check("restart_resync", VW'(resync), VW'(1));
    send_rows(1'b0, 1, SLOTS - 1, 0, 0);

    // Row 3 on in slots 2, 3 and 10 only: level 3, not monotonic.
    fill(ramp);
    for (int n = 0; n < SLOTS; n++) slot_rows[n][3] = (n == 2 || n == 3 || n == 10);
    send_rows(1'b1, 0, SLOTS - 1, 0, 0);
    check("row3_level", VW'(values[19:15]), VW'(3));
    check("row3_mono", VW'(mono_err), VW'(1));

    // Reset at slot 7; unframed samples are ignored until the next frame_start.
    fill(ramp);
    send_rows(1'b1, 0, 6, 0, 0);
    apply_reset();
    send_rows(1'b0, 0, SLOTS - 1, 0, 0);
    check("unframed_ignored", values, '0);
    send_rows(1'b1, 0, SLOTS - 1, 0, 1);

    // Random frames: random levels, optional frame_start, gaps, partial frames,
    // and occasional flipped bits.
    for (int f = 0; f < 25; f++) begin
      for (int j = 0; j < ROWS; j++) vals[j] = $urandom_range(0, 31);
      fill(vals);
      if ($urandom_range(0, 4) == 0) slot_rows[$urandom_range(0, SLOTS - 1)][$urandom_range(0, ROWS - 1)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0) begin
        send_rows(1'b1, 0, $urandom_range(1, SLOTS - 2), 0, 1);
        send_rows(1'b1, 0, SLOTS - 1, 0, 2);
      end else begin
        send_rows(bit'($urandom_range(0, 1)), 0, SLOTS - 1, 0, 2);
      end
    end
    gap(3);

    check("exp_q_drained", VW'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
